// File: rtl/jtgng_dwnld_router_if.sv
// Download-router bus: ioctl byte stream in, SDRAM program handshake and PROM strobes out.
// The master side is the host/game top-level; the slave side is the router.
interface jtgng_dwnld_router_if #(
  parameter int AW         = 22,
  parameter int PROM_AW    = 8,
  parameter int PROM_COUNT = 10
);
  logic                  downloading;
  logic                  ioctl_wr;
  logic [AW-1:0]         ioctl_addr;
  logic [7:0]            ioctl_data;
  logic [AW-1:0]         prog_addr;
  logic [7:0]            prog_data;
  logic [1:0]            prog_mask;
  logic                  prog_we;
  logic                  prog_ack;
  logic [PROM_COUNT-1:0] prom_we;
  logic [PROM_AW-1:0]    prom_addr;
  logic [3:0]            prom_data;
  logic                  overflow;
  logic                  dwnld_done;

  modport master (
    output downloading, ioctl_wr, ioctl_addr, ioctl_data, prog_ack,
    input  prog_addr, prog_data, prog_mask, prog_we,
           prom_we, prom_addr, prom_data, overflow, dwnld_done
  );

  modport slave (
    input  downloading, ioctl_wr, ioctl_addr, ioctl_data, prog_ack,
    output prog_addr, prog_data, prog_mask, prog_we,
           prom_we, prom_addr, prom_data, overflow, dwnld_done
  );
endinterface

// File: rtl/jtgng_dwnld_fifo.sv
// Small synchronous FIFO for ROM bytes; pointers carry a wrap bit to tell full from empty.
// head/head_vld give the read-side view after this cycle's pop, ignoring this cycle's push.
module jtgng_dwnld_fifo #(
  parameter int AW = 2,
  parameter int DW = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic          head_vld,
  output logic [DW-1:0] head
);
  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, rd_nxt;

  assign rd_nxt   = rd_ptr + {{AW{1'b0}}, pop};
  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_vld = wr_ptr != rd_nxt;
  assign head     = mem[rd_nxt[AW-1:0]];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= din;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      rd_ptr <= rd_nxt;
    end
endmodule

// File: rtl/jtgng_dwnld_router.sv
// Routes ioctl download bytes: ROM bytes through an elastic FIFO to SDRAM programming,
// PROM bytes to one-hot nibble write strobes, and signals when a download has fully drained.
//
// state | meaning
// IDLE  | no download active, waiting for downloading to rise
// LOAD  | download in progress
// DRAIN | download ended, waiting for the ROM FIFO to empty
module jtgng_dwnld_router #(
  parameter int            AW         = 22,
  parameter logic [AW-1:0] PROM_START = 'h1E000,
  parameter int            PROM_AW    = 8,
  parameter int            PROM_COUNT = 10,
  parameter int            FIFO_AW    = 2
) (
  input logic clk,
  input logic rst,
  jtgng_dwnld_router_if.slave bus
);
  localparam int EW = AW - 1 + 8 + 2;

  typedef enum logic [1:0] { IDLE, LOAD, DRAIN } state_t;

  state_t                state;
  logic                  dl_q, rise, fall;
  logic                  accept, is_rom, push, pop, drop, prom_hit;
  logic                  ff_full, ff_empty, ff_vld;
  logic [EW-1:0]         ff_din, ff_head;
  logic [AW-1:0]         off, idx;
  logic                  prog_we_r, ovf_r, done_r;
  logic [AW-1:0]         prog_addr_r;
  logic [7:0]            prog_data_r;
  logic [1:0]            prog_mask_r;
  logic [PROM_COUNT-1:0] prom_we_r;
  logic [PROM_AW-1:0]    prom_addr_r;
  logic [3:0]            prom_data_r;

  assign accept   = bus.ioctl_wr && bus.downloading;
  assign is_rom   = bus.ioctl_addr < PROM_START;
  assign pop      = prog_we_r && bus.prog_ack;
  assign push     = accept && is_rom && (!ff_full || pop);
  assign drop     = accept && is_rom && ff_full && !pop;
  assign ff_din   = {bus.ioctl_addr[AW-1:1], bus.ioctl_data, bus.ioctl_addr[0] ? 2'b01 : 2'b10};
  assign off      = bus.ioctl_addr - PROM_START;
  assign idx      = off >> PROM_AW;
  assign prom_hit = accept && !is_rom && (idx < AW'(PROM_COUNT));
  assign rise     = bus.downloading && !dl_q;
  assign fall     = !bus.downloading && dl_q;

  jtgng_dwnld_fifo #(.AW(FIFO_AW), .DW(EW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .din      (ff_din),
    .full     (ff_full),
    .empty    (ff_empty),
    .head_vld (ff_vld),
    .head     (ff_head)
  );

  // Head registers only reload on a valid entry, so they hold still during a stall.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prog_we_r   <= 1'b0;
      prog_addr_r <= '0;
      prog_data_r <= '0;
      prog_mask_r <= '0;
      prom_we_r   <= '0;
      prom_addr_r <= '0;
      prom_data_r <= '0;
    end else begin
      prog_we_r <= ff_vld;
      if (ff_vld) begin
        prog_addr_r <= {1'b0, ff_head[EW-1:10]};
        prog_data_r <= ff_head[9:2];
        prog_mask_r <= ff_head[1:0];
      end
      prom_we_r <= prom_hit ? ({{(PROM_COUNT-1){1'b0}}, 1'b1} << idx) : '0;
      if (prom_hit) begin
        prom_addr_r <= off[PROM_AW-1:0];
        prom_data_r <= bus.ioctl_data[3:0];
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      dl_q   <= 1'b0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      dl_q   <= bus.downloading;
      done_r <= 1'b0;
      if (rise) ovf_r <= 1'b0;
      if (drop) ovf_r <= 1'b1;
      case (state)
        IDLE:    if (rise) state <= LOAD;
        LOAD:    if (fall) state <= DRAIN;
        DRAIN:   if (rise) state <= LOAD;
                 else if (ff_empty) begin
                   state  <= IDLE;
                   done_r <= 1'b1;
                 end
        default: state <= IDLE;
      endcase
    end

  assign bus.prog_we    = prog_we_r;
  assign bus.prog_addr  = prog_addr_r;
  assign bus.prog_data  = prog_data_r;
  assign bus.prog_mask  = prog_mask_r;
  assign bus.prom_we    = prom_we_r;
  assign bus.prom_addr  = prom_addr_r;
  assign bus.prom_data  = prom_data_r;
  assign bus.overflow   = ovf_r;
  assign bus.dwnld_done = done_r;
endmodule

// File: tb/tb_jtgng_dwnld_router.sv
// Directed bench for jtgng_dwnld_router: ROM FIFO handshake, overflow, PROM decode, done FSM, reset.
module tb_jtgng_dwnld_router;
  logic clk, rst;
  int   errors = 0;
  int   checks = 0;

  jtgng_dwnld_router_if #(.AW(22), .PROM_AW(8), .PROM_COUNT(10)) bus ();

  jtgng_dwnld_router #(
    .AW(22), .PROM_START(22'h1E000), .PROM_AW(8), .PROM_COUNT(10), .FIFO_AW(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [21:0] a, input logic [7:0] d);
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.downloading = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0;
    bus.ioctl_data = '0; bus.prog_ack = 1'b0;
    #1;
    checks++; if (bus.prog_we !== 1'b0) begin errors++; $display("FAIL reset_prog_we got=%0b exp=0", bus.prog_we); end
    checks++; if (bus.prog_addr !== 22'h0) begin errors++; $display("FAIL reset_prog_addr got=%h exp=0", bus.prog_addr); end
    checks++; if (bus.prog_data !== 8'h0) begin errors++; $display("FAIL reset_prog_data got=%h exp=0", bus.prog_data); end
    checks++; if (bus.prog_mask !== 2'b00) begin errors++; $display("FAIL reset_prog_mask got=%b exp=00", bus.prog_mask); end
    checks++; if (bus.prom_we !== 10'h0) begin errors++; $display("FAIL reset_prom_we got=%b exp=0", bus.prom_we); end
    checks++; if (bus.prom_addr !== 8'h0 || bus.prom_data !== 4'h0) begin errors++; $display("FAIL reset_prom_bus got=%h/%h exp=0/0", bus.prom_addr, bus.prom_data); end
    checks++; if (bus.overflow !== 1'b0 || bus.dwnld_done !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", bus.overflow, bus.dwnld_done); end
    tick(); tick();
    rst = 1'b0;
    bus.downloading = 1'b1;
    tick();
  endtask

  task automatic test_rom_no_stall();
    bus.prog_ack = 1'b1;
    wr(22'h00005, 8'hA5);
    checks++; if (bus.prog_we !== 1'b0) begin errors++; $display("FAIL rom_latency got=%0b exp=0", bus.prog_we); end
    tick();
    checks++; if (bus.prog_we !== 1'b1) begin errors++; $display("FAIL rom_we got=%0b exp=1", bus.prog_we); end
    checks++; if (bus.prog_addr !== 22'h00002) begin errors++; $display("FAIL rom_addr got=%h exp=00002", bus.prog_addr); end
    checks++; if (bus.prog_data !== 8'hA5) begin errors++; $display("FAIL rom_data got=%h exp=a5", bus.prog_data); end
    checks++; if (bus.prog_mask !== 2'b01) begin errors++; $display("FAIL rom_mask got=%b exp=01", bus.prog_mask); end
    tick();
    checks++; if (bus.prog_we !== 1'b0) begin errors++; $display("FAIL rom_gone got=%0b exp=0", bus.prog_we); end
  endtask

  task automatic test_stall_overflow();
    logic [21:0] ea [4] = '{22'h0, 22'h0, 22'h1, 22'h1};
    logic [1:0]  em [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    bus.prog_ack = 1'b0;
    for (int i = 0; i < 5; i++) wr(22'(i), 8'(8'h10 + i));
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL stall_overflow got=%0b exp=1", bus.overflow); end
    tick();
    checks++; if (bus.prog_we !== 1'b1 || bus.prog_data !== 8'h10) begin errors++; $display("FAIL stall_hold got=%0b/%h exp=1/10", bus.prog_we, bus.prog_data); end
    bus.prog_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.prog_we !== 1'b1 || bus.prog_addr !== ea[k] || bus.prog_data !== 8'(8'h10 + k) || bus.prog_mask !== em[k]) begin
        errors++;
        $display("FAIL stall_drain%0d got=%0b/%h/%h/%b exp=1/%h/%h/%b", k, bus.prog_we, bus.prog_addr, bus.prog_data, bus.prog_mask, ea[k], 8'(8'h10 + k), em[k]);
      end
      tick();
    end
    checks++; if (bus.prog_we !== 1'b0) begin errors++; $display("FAIL stall_dropped_absent got=%0b exp=0", bus.prog_we); end
    // FIFO already empty at the fall: done comes the cycle after the fall is seen
    bus.downloading = 1'b0;
    tick();
    checks++; if (bus.dwnld_done !== 1'b0) begin errors++; $display("FAIL done_early got=%0b exp=0", bus.dwnld_done); end
    tick();
    checks++; if (bus.dwnld_done !== 1'b1) begin errors++; $display("FAIL done_empty_fall got=%0b exp=1", bus.dwnld_done); end
    tick();
    checks++; if (bus.dwnld_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%0b exp=0", bus.dwnld_done); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got=%0b exp=1", bus.overflow); end
    bus.downloading = 1'b1;
    tick();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got=%0b exp=0", bus.overflow); end
  endtask

  task automatic test_full_pop();
    logic [21:0] ea [4] = '{22'h10, 22'h11, 22'h11, 22'h12};
    bus.prog_ack = 1'b0;
    for (int i = 0; i < 4; i++) wr(22'(22'h20 + i), 8'(8'h40 + i));
    bus.prog_ack = 1'b1;
    wr(22'h24, 8'h44);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got=%0b exp=0", bus.overflow); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.prog_we !== 1'b1 || bus.prog_addr !== ea[k] || bus.prog_data !== 8'(8'h41 + k)) begin
        errors++;
        $display("FAIL fullpop_drain%0d got=%0b/%h/%h exp=1/%h/%h", k, bus.prog_we, bus.prog_addr, bus.prog_data, ea[k], 8'(8'h41 + k));
      end
      tick();
    end
    checks++; if (bus.prog_we !== 1'b0) begin errors++; $display("FAIL fullpop_count got=%0b exp=0", bus.prog_we); end
  endtask

  task automatic test_prom();
    wr(22'h1E105, 8'h3C);
    checks++; if (bus.prom_we !== 10'b0000000010) begin errors++; $display("FAIL prom_we got=%b exp=0000000010", bus.prom_we); end
    checks++; if (bus.prom_addr !== 8'h05 || bus.prom_data !== 4'hC) begin errors++; $display("FAIL prom_addr_data got=%h/%h exp=05/c", bus.prom_addr, bus.prom_data); end
    tick();
    checks++; if (bus.prom_we !== 10'h0 || bus.prog_we !== 1'b0) begin errors++; $display("FAIL prom_pulse got=%b/%0b exp=0/0", bus.prom_we, bus.prog_we); end
    wr(22'h1EA00, 8'h77);
    checks++; if (bus.prom_we !== 10'h0) begin errors++; $display("FAIL prom_oob_we got=%b exp=0", bus.prom_we); end
    tick();
    checks++; if (bus.prom_we !== 10'h0 || bus.prog_we !== 1'b0) begin errors++; $display("FAIL prom_oob_quiet got=%b/%0b exp=0/0", bus.prom_we, bus.prog_we); end
  endtask

  task automatic test_done_and_reset();
    bus.prog_ack = 1'b0;
    for (int i = 0; i < 3; i++) wr(22'(22'h30 + i), 8'(8'h50 + i));
    bus.downloading = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.dwnld_done !== 1'b0) begin errors++; $display("FAIL done_stalled%0d got=%0b exp=0", i, bus.dwnld_done); end
    end
    bus.prog_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.dwnld_done !== 1'b0) begin errors++; $display("FAIL done_during_drain%0d got=%0b exp=0", i, bus.dwnld_done); end
    end
    tick();
    checks++; if (bus.dwnld_done !== 1'b1) begin errors++; $display("FAIL done_after_drain got=%0b exp=1", bus.dwnld_done); end
    tick();
    checks++; if (bus.dwnld_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%0b exp=0", bus.dwnld_done); end
    // writes outside a download must be ignored
    wr(22'h00040, 8'h99);
    tick();
    checks++; if (bus.prog_we !== 1'b0) begin errors++; $display("FAIL ignore_idle got=%0b exp=0", bus.prog_we); end
    // second pass: overflow, fall, then reset mid-drain
    bus.downloading = 1'b1;
    tick();
    bus.prog_ack = 1'b0;
    for (int i = 0; i < 5; i++) wr(22'(22'h60 + i), 8'(8'h70 + i));
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL rst_pre_overflow got=%0b exp=1", bus.overflow); end
    bus.downloading = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (bus.prog_we !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_async got=%0b/%0b exp=0/0", bus.prog_we, bus.overflow); end
    tick();
    bus.prog_ack = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.dwnld_done !== 1'b0 || bus.prog_we !== 1'b0 || bus.overflow !== 1'b0) begin
        errors++;
        $display("FAIL rst_flushed%0d got=%0b/%0b/%0b exp=0/0/0", i, bus.dwnld_done, bus.prog_we, bus.overflow);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rom_no_stall();
    test_stall_overflow();
    test_full_pop();
    test_prom();
    test_done_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
